// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the 1x3 router output scheduler
package router_pkg;
    typedef enum logic [1:0] {IDLE, PEND, FLUSH} port_state_e;
    localparam int NPORT = 3;
    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int TIMEOUT_DEF = 30;
endpackage

// File: rtl/router_port_timer.sv
// router_port_timer: per-port pending/timeout FSM that flushes an unread FIFO
module router_port_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic fifo_empty,
    input  logic read_enb,
    output logic vld_out,
    output logic soft_rst
);
    localparam int CW = $clog2(TIMEOUT);
    port_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: state_d = fifo_empty ? IDLE : PEND;
            PEND: begin
                // empty wins over read, read wins over timeout
                if (fifo_empty) state_d = IDLE;
                else if (!read_enb && cnt_q == CW'(TIMEOUT - 1)) state_d = FLUSH;
                else if (!read_enb) cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    assign vld_out  = (state_q == PEND);
    assign soft_rst = (state_q == FLUSH);
endmodule

// File: rtl/router_port_sched.sv
// router_port_sched: latches the destination, steers writes to one of three FIFOs
// and runs a timeout flush per output port
module router_port_sched
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             detect_addr,
    input  logic [1:0]       din,
    input  logic             write_enb_reg,
    input  logic [NPORT-1:0] read_enb,
    input  logic [NPORT-1:0] fifo_empty,
    input  logic [NPORT-1:0] fifo_full_in,
    output logic [NPORT-1:0] write_enb,
    output logic             fifo_full,
    output logic [NPORT-1:0] vld_out,
    output logic [NPORT-1:0] soft_rst
);
    logic [1:0] addr_q, addr_d;
    logic       addr_vld_q, addr_vld_d;
    assign addr_d     = (detect_addr && din != ADDR_INVALID) ? din : addr_q;
    assign addr_vld_d = detect_addr ? (din != ADDR_INVALID) : addr_vld_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            addr_vld_q <= addr_vld_d;
        end
    end
    // addr_q only ever holds a valid port, so the index stays in range
    assign fifo_full = addr_vld_q & fifo_full_in[addr_q];
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        router_port_timer #(.TIMEOUT(TIMEOUT)) u_timer (
            .clk       (clk),
            .rst       (rst),
            .fifo_empty(fifo_empty[p]),
            .read_enb  (read_enb[p]),
            .vld_out   (vld_out[p]),
            .soft_rst  (soft_rst[p])
        );
        assign write_enb[p] = write_enb_reg & addr_vld_q & (addr_q == 2'(p)) & ~soft_rst[p];
    end
endmodule

// File: tb/tb_router_port_sched.sv
// tb_router_port_sched: directed checks of address latch, write steering and timeout flush
module tb_router_port_sched;
    logic       clk = 0;
    logic       rst = 1;
    logic       detect_addr = 0;
    logic [1:0] din = 0;
    logic       write_enb_reg = 0;
    logic [2:0] read_enb = 0;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] fifo_full_in = 0;
    logic [2:0] write_enb, vld_out, soft_rst;
    logic       fifo_full;
    int n_run = 0;
    int n_fail = 0;

    router_port_sched #(.TIMEOUT(30)) dut (
        .clk(clk), .rst(rst), .detect_addr(detect_addr), .din(din),
        .write_enb_reg(write_enb_reg), .read_enb(read_enb), .fifo_empty(fifo_empty),
        .fifo_full_in(fifo_full_in), .write_enb(write_enb), .fifo_full(fifo_full),
        .vld_out(vld_out), .soft_rst(soft_rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [1:0] a);
        detect_addr = 1;
        din = a;
        step();
        detect_addr = 0;
        #1;
    endtask

    initial begin
        step();
        step();
        check("reset_outs", {write_enb, fifo_full, vld_out, soft_rst}, 10'h0);
        rst = 0;
        // address 1: no write in the detect cycle, steering from the next
        detect_addr = 1; din = 1; write_enb_reg = 1; fifo_full_in = 3'b010;
        #1;
        check("we_detect_cycle", write_enb, 3'b000);
        step();
        detect_addr = 0;
        #1;
        check("we_addr1", write_enb, 3'b010);
        check("full_addr1", fifo_full, 1'b1);
        fifo_full_in = 3'b101;
        #1;
        check("full_addr1_low", fifo_full, 1'b0);
        set_addr(2);
        check("we_addr2", write_enb, 3'b100);
        check("full_addr2", fifo_full, 1'b1);
        // invalid address blocks writes and masks full
        fifo_full_in = 3'b111;
        set_addr(3);
        check("we_invalid", write_enb, 3'b000);
        check("full_invalid", fifo_full, 1'b0);
        // port 0 timeout with writes steered to it
        set_addr(0);
        check("we_addr0", write_enb, 3'b001);
        fifo_empty[0] = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            check($sformatf("t1_vld_c%0d", c), {vld_out, soft_rst}, 6'b001_000);
        end
        check("t1_we_c30", write_enb, 3'b001);
        step();
        check("t1_flush_c31", {vld_out, soft_rst}, 6'b000_001);
        check("t1_we_suppressed", write_enb, 3'b000);
        fifo_empty[0] = 1;
        step();
        check("t1_idle_c32", {vld_out, soft_rst}, 6'b000_000);
        check("t1_we_restored", write_enb, 3'b001);
        // read pulse in the 30th PEND cycle restarts the count
        fifo_empty[0] = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            check($sformatf("t2_vld_c%0d", c), {vld_out, soft_rst}, 6'b001_000);
        end
        read_enb[0] = 1;
        for (int c = 31; c <= 60; c++) begin
            step();
            read_enb[0] = 0;
            check($sformatf("t2_vld_c%0d", c), {vld_out, soft_rst}, 6'b001_000);
        end
        step();
        check("t2_flush_c61", {vld_out, soft_rst}, 6'b000_001);
        fifo_empty[0] = 1;
        step();
        check("t2_idle", {vld_out, soft_rst}, 6'b000_000);
        // port 2: empty and read together drop to IDLE, new timeout starts at 0
        fifo_empty[2] = 0;
        for (int c = 0; c < 5; c++) step();
        check("t3_pend", vld_out, 3'b100);
        fifo_empty[2] = 1; read_enb[2] = 1;
        step();
        read_enb[2] = 0;
        check("t3_idle", {vld_out, soft_rst}, 6'b000_000);
        fifo_empty[2] = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            check($sformatf("t3_vld_c%0d", c), {vld_out, soft_rst}, 6'b100_000);
        end
        step();
        check("t3_flush", {vld_out, soft_rst}, 6'b000_100);
        fifo_empty[2] = 1;
        step();
        // reset during port 1 flush while writing to port 1
        set_addr(1);
        fifo_empty[1] = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            check($sformatf("t4_vld_c%0d", c), {vld_out, soft_rst}, 6'b010_000);
        end
        check("t4_we_c30", write_enb, 3'b010);
        step();
        check("t4_flush", {vld_out, soft_rst, write_enb}, 9'b000_010_000);
        rst = 1;
        step();
        rst = 0;
        check("t4_reset_outs", {write_enb, fifo_full, vld_out, soft_rst}, 10'h0);
        fifo_empty[1] = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("t4_blocked_%0d", c), {write_enb, fifo_full, soft_rst}, 7'h0);
        end
        set_addr(1);
        check("t4_we_relatch", write_enb, 3'b010);
        check("t4_full_relatch", fifo_full, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/router_port_sched.md
# router_port_sched

Output-side scheduler for the 1x3 router. It latches the destination address decoded by the router controller and steers the write enable to one of the three output FIFOs. It also returns that FIFO's full flag to the controller. For each output port it runs a timeout state machine that raises `vld_out` while data is pending and pulses `soft_rst` to flush the FIFO when the destination does not read within `TIMEOUT` cycles.

## Interface
- `TIMEOUT`, default 30: consecutive no-read cycles with `vld_out` high before a flush; legal range 2..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `detect_addr` input 1: controller is in address-decode state; `din` carries the destination.
- `din` input 2: destination address; 0/1/2 are valid, 3 is invalid.
- `write_enb_reg` input 1: controller requests a write of the current byte.
- `read_enb` input 3: per-port read strobe from the destination.
- `fifo_empty` input 3: per-port FIFO empty flag.
- `fifo_full_in` input 3: per-port FIFO full flag.
- `write_enb` output 3: one-hot FIFO write enable.
- `fifo_full` output 1: full flag of the addressed FIFO, returned to the controller.
- `vld_out` output 3: per-port data-pending indication to the destination.
- `soft_rst` output 3: per-port one-cycle FIFO flush pulse.

## Operation
- Address latch:
  - `addr` (2 bits) and `addr_vld` are registered.
  - When `detect_addr`=1 and `din`≠3: `addr`←`din`, `addr_vld`←1.
  - When `detect_addr`=1 and `din`=3: `addr_vld`←0 and `addr` holds.
  - Otherwise both hold.
- `write_enb[p]` = `write_enb_reg` & `addr_vld` & (`addr`==p) & ~`soft_rst[p]`. This path is combinational from the registers.
- `fifo_full` = `addr_vld` ? `fifo_full_in[addr]` : 0.
- Per-port FSM, with states IDLE, PEND, FLUSH and a counter `cnt`:
  - IDLE: `vld_out`=0, `cnt`=0. If `fifo_empty`=0 → PEND.
  - PEND: `vld_out`=1.
    - `fifo_empty`=1 → IDLE. This has priority over all other PEND transitions.
    - Else if `read_enb`=1 → `cnt`←0, stay in PEND.
    - Else if `cnt`==TIMEOUT-1 → FLUSH.
    - Else `cnt`←`cnt`+1.
  - FLUSH: `soft_rst`=1, `vld_out`=0, `cnt`←0. Unconditionally → IDLE on the next edge.
- The three port FSMs are independent; they share no state.
- Reset values: all FSMs IDLE, `cnt`=0, `addr`=0, `addr_vld`=0. All outputs are 0, and `fifo_full` is 0 because `addr_vld`=0.

## Timing
- `vld_out[p]` and `soft_rst[p]` are Moore outputs, registered through the state.
- `vld_out` rises on the first edge after `fifo_empty` falls, giving 1 cycle of latency.
- Flush timing: if `read_enb[p]` stays low for TIMEOUT consecutive PEND cycles, `soft_rst[p]` is high for exactly the next cycle.
- The FIFO clears on the edge that ends the FLUSH cycle. The FSM is back in IDLE on that same edge, so it sees `fifo_empty`=1 and does not retrigger.
- A `read_enb` in any PEND cycle, including the TIMEOUT-th, restarts the count. No flush occurs in that case.
- `write_enb`/`fifo_full` follow `addr` one cycle after the `detect_addr` cycle.
- A write to a port in FLUSH is suppressed for that cycle; the controller is not stalled.
- `rst` mid-operation:
  - Any FLUSH pulse is aborted (no `soft_rst` on the following cycle).
  - Counters clear, and `addr_vld`=0 blocks writes until the next valid `detect_addr`.
- Counter width is ceil(log2(TIMEOUT)) bits and never wraps: it saturates at TIMEOUT-1 by construction.

## Structure
- Shared package `router_pkg`:
  - Port-state enum (IDLE/PEND/FLUSH).
  - `NPORT`=3.
  - `ADDR_INVALID`=2'b11.
  - Default timeout constant 30.
- Sub-module `router_port_timer`:
  - One port's FSM plus counter.
  - Inputs: `clk`, `rst`, `fifo_empty`, `read_enb`.
  - Outputs: `vld_out`, `soft_rst`.
  - Instantiated three times.
- The top level holds the address latch, write-enable decode and full mux.

## Test plan
- Reset, then `detect_addr`=1 with `din`=1, then `write_enb_reg`=1 → `write_enb`=3'b010 from the next cycle; `fifo_full` tracks `fifo_full_in[1]`.
- `detect_addr` with `din`=3, then `write_enb_reg`=1 → `write_enb`=0 and `fifo_full`=0.
- Port 0 `fifo_empty` falls at cycle 0, `read_enb[0]` held low (TIMEOUT=30) → `vld_out[0]`=1 over cycles 1–30, `soft_rst[0]`=1 only in cycle 31, IDLE in cycle 32.
- As the previous case, but `read_enb[0]` pulses at PEND cycle 30 → no `soft_rst`; a flush then occurs 30 cycles after the pulse.
- Port 2 `fifo_empty` rises in the same cycle as `read_enb[2]` → `vld_out[2]` is 0 the next cycle and `cnt` is 0.
- `rst` asserted during a port 1 FLUSH cycle while `addr`=1 and `write_enb_reg`=1 → next cycle all outputs are 0, and no writes occur until a new valid `detect_addr`.
